async_fifo_wr_ctrl: RTL
=======================

// Module: async_fifo_wr_ctrl
// PURPOSE
//  Write-domain pointer/flag controller of the dual-clock FIFO.
//  - Owns the binary write counter and the registered Gray write pointer WR_PTR, which feeds the
//    read-domain pointer synchronizer.
//  - Consumes the read pointer already synchronized into the write clock domain and produces a
//    registered FULL flag, the memory write address and the memory write enable.
// PARAMETERS
//  P_SIZE    3  address width; FIFO depth = 2**P_SIZE; pointers are P_SIZE+1 bits; legal range P_SIZE >= 2
//  AF_LEVEL  6  almost-full threshold in entries; used only when ASYNC_FIFO_AFULL_EN is defined;
//               legal range 1..2**P_SIZE
// PORTS
//  CLK          in   1         write-domain clock
//  RST          in   1         asynchronous active-low reset
//  W_INC        in   1         write request, one entry per cycle while high
//  RD_PTR_SYNC  in   P_SIZE+1  Gray read pointer, already synchronized to CLK
//  W_ADDR       out  P_SIZE    memory write address
//  W_EN_MEM     out  1         memory write enable = W_INC & ~FULL (combinational)
//  WR_PTR       out  P_SIZE+1  registered Gray write pointer, sent to the synchronizer
//  FULL         out  1         registered full flag
//  AFULL        out  1         registered almost-full flag (present only with ASYNC_FIFO_AFULL_EN)
// BEHAVIOUR
//  - Reset: internal binary counter WR_BIN = 0, WR_PTR = 0, FULL = 0, AFULL = 0; W_ADDR = 0 follows.
//    Reset mid-operation clears all state immediately (asynchronous assert), with no partial write.
//  - Accepted write: a write is accepted when W_INC & ~FULL.
//    bin_nxt = WR_BIN + accepted, wrapping modulo 2**(P_SIZE+1).
//    gray_nxt = (bin_nxt >> 1) ^ bin_nxt.
//    WR_BIN <= bin_nxt; WR_PTR <= gray_nxt. WR_PTR is always a registered Gray value, never combinational.
//  - W_ADDR = WR_BIN[P_SIZE-1:0]: the address of the current write. It advances one cycle after an
//    accepted write.
//  - FULL <= (gray_nxt == {~RD_PTR_SYNC[P_SIZE:P_SIZE-1], RD_PTR_SYNC[P_SIZE-2:0]}).
//    FULL rises in the cycle after the write that fills the last entry.
//    FULL is re-evaluated every cycle, so it falls one CLK edge after RD_PTR_SYNC shows a read.
//  - Write while FULL: ignored. W_EN_MEM = 0, and WR_BIN, WR_PTR and W_ADDR hold. There is no
//    overflow side effect.
//  - Simultaneous write and read-pointer change: both are used in the same evaluation. The FULL
//    result reflects gray_nxt against the current RD_PTR_SYNC.
//  - Pessimism: FULL may stay high up to synchronizer-latency cycles after the physical read.
//    This is correct by design. FULL never deasserts early.
//  - Wrap-around: the MSB toggles every 2**P_SIZE writes. The Gray encoding guarantees that
//    WR_PTR changes exactly one bit per accepted write.
// CONFIGURATION
//  ASYNC_FIFO_AFULL_EN defined:
//   - rbin = Gray-to-binary(RD_PTR_SYNC).
//   - level_nxt = (bin_nxt - rbin) mod 2**(P_SIZE+1).
//   - AFULL <= (level_nxt >= AF_LEVEL). Same registered timing as FULL.
//  ASYNC_FIFO_AFULL_EN undefined: no AFULL port, no subtractor and no Gray-to-binary logic.
//   FULL behaviour is identical in both builds.
// TESTING (P_SIZE=3, AF_LEVEL=6)
//  1. Reset: assert RST=0 mid-stream -> WR_PTR=0, W_ADDR=0, FULL=0, AFULL=0 without waiting for CLK.
//  2. Fill: RD_PTR_SYNC=0, 8 consecutive W_INC ->
//     - W_ADDR steps 0..7;
//     - WR_PTR steps 1,3,2,6,7,5,4,12;
//     - FULL=1 in the cycle after the 8th write.
//  3. Write when full: hold W_INC=1 for 3 more cycles -> W_EN_MEM=0; WR_PTR stays 4'b1100 and
//     W_ADDR stays 0.
//  4. Release: drive RD_PTR_SYNC=4'b0001 -> FULL=0 after the next edge; one further write is
//     accepted and FULL re-asserts.
//  5. Wrap: 16 writes interleaved with RD_PTR_SYNC tracking 2 entries behind -> FULL never set;
//     WR_PTR returns to 0; a checker confirms every WR_PTR step flips exactly one bit.
//  6. AFULL build: from empty, 6 writes -> AFULL=1 after the 6th; RD_PTR_SYNC advanced by 1 (Gray)
//     -> AFULL=0 next cycle.

Source files
------------

// File: rtl/async_fifo_wr_ctrl.sv
// ---------------------------------------------------------------------------
// async_fifo_wr_ctrl
// Write-domain pointer/flag controller of the dual-clock FIFO.
//
// Holds the binary write counter and the registered Gray write pointer that
// is handed to the read-domain synchronizer. It compares the next Gray write
// pointer against the read pointer, which has already been synchronized into
// CLK, and produces a registered FULL flag.
//
// Optional feature macro: ASYNC_FIFO_AFULL_EN
//   When defined, the block adds a registered AFULL output. AFULL is set when
//   the fill level is AF_LEVEL or more. When the macro is undefined, the block
//   has no AFULL port and builds no Gray-to-binary or subtract logic.
//
// Parameters
//   P_SIZE       address width; depth = 2**P_SIZE; pointers are P_SIZE+1 bits
//   AF_LEVEL     almost-full threshold in entries (1 .. 2**P_SIZE)
//
// Ports
//   CLK          in   write-domain clock
//   RST          in   asynchronous active-low reset
//   W_INC        in   write request, one entry per cycle while high
//   RD_PTR_SYNC  in   Gray read pointer, synchronized to CLK
//   W_ADDR       out  memory write address (low bits of binary counter)
//   W_EN_MEM     out  memory write enable = W_INC & ~FULL
//   WR_PTR       out  registered Gray write pointer
//   FULL         out  registered full flag
//   AFULL        out  registered almost-full flag (ASYNC_FIFO_AFULL_EN only)
// ---------------------------------------------------------------------------
module async_fifo_wr_ctrl #(
  parameter int P_SIZE   = 3,
  parameter int AF_LEVEL = 6
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              W_INC,
  input  logic [P_SIZE:0]   RD_PTR_SYNC,
  output logic [P_SIZE-1:0] W_ADDR,
  output logic              W_EN_MEM,
  output logic [P_SIZE:0]   WR_PTR,
  output logic              FULL
`ifdef ASYNC_FIFO_AFULL_EN
  ,
  output logic              AFULL
`endif
);

  // Reject parameter sets outside the legal range at elaboration time.
  if ((P_SIZE < 2) || (AF_LEVEL < 1) || (AF_LEVEL > (1 << P_SIZE))) begin : g_param_check
    $error("async_fifo_wr_ctrl: illegal P_SIZE/AF_LEVEL");
  end

  // Convert binary to reflected Gray code.
  function automatic logic [P_SIZE:0] bin2gray(input logic [P_SIZE:0] b);
    return (b >> 1) ^ b;
  endfunction

  logic [P_SIZE:0] wr_bin_r;
  logic [P_SIZE:0] wr_ptr_r;
  logic            full_r;

  logic            wr_accept_s;
  logic [P_SIZE:0] bin_nxt_s;
  logic [P_SIZE:0] gray_nxt_s;
  logic [P_SIZE:0] full_cmp_s;
  logic            full_nxt_s;

  // Next-pointer and full-detect logic.
  always_comb begin
    wr_accept_s = W_INC & ~full_r;
    bin_nxt_s   = wr_bin_r + {{P_SIZE{1'b0}}, wr_accept_s};
    gray_nxt_s  = bin2gray(bin_nxt_s);
    // The FIFO is full when the write pointer is one whole lap ahead of the
    // read pointer. In Gray code, this means the top two bits are inverted
    // and the remaining bits are equal.
    full_cmp_s  = {~RD_PTR_SYNC[P_SIZE:P_SIZE-1], RD_PTR_SYNC[P_SIZE-2:0]};
    full_nxt_s  = (gray_nxt_s == full_cmp_s);
  end

  // Write counter, Gray pointer and FULL registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_bin_r <= {(P_SIZE+1){1'b0}};
      wr_ptr_r <= {(P_SIZE+1){1'b0}};
      full_r   <= 1'b0;
    end else begin
      wr_bin_r <= bin_nxt_s;
      wr_ptr_r <= gray_nxt_s;
      full_r   <= full_nxt_s;
    end
  end

`ifdef ASYNC_FIFO_AFULL_EN
  localparam logic [P_SIZE:0] AF_LEVEL_C = (P_SIZE+1)'(AF_LEVEL);

  // Convert reflected Gray code back to binary (prefix XOR from the MSB down).
  function automatic logic [P_SIZE:0] gray2bin(input logic [P_SIZE:0] g);
    logic [P_SIZE:0] b;
    b[P_SIZE] = g[P_SIZE];
    for (int i = P_SIZE - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [P_SIZE:0] rbin_s;
  logic [P_SIZE:0] level_nxt_s;
  logic            afull_nxt_s;
  logic            afull_r;

  // Fill-level computation for almost-full. The subtraction wraps modulo 2**(P_SIZE+1).
  always_comb begin
    rbin_s      = gray2bin(RD_PTR_SYNC);
    level_nxt_s = bin_nxt_s - rbin_s;
    afull_nxt_s = (level_nxt_s >= AF_LEVEL_C);
  end

  // AFULL register, timed the same way as FULL.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      afull_r <= 1'b0;
    end else begin
      afull_r <= afull_nxt_s;
    end
  end

  assign AFULL = afull_r;
`endif

  assign W_ADDR   = wr_bin_r[P_SIZE-1:0];
  assign W_EN_MEM = wr_accept_s;
  assign WR_PTR   = wr_ptr_r;
  assign FULL     = full_r;

endmodule
